mcla_addseq: RTL

- Multi-cycle wide adder sequencer. It time-multiplexes one 16-bit carry-lookahead adder slice to add two WIDTH-bit operands, one 16-bit slice per cycle, LSB slice first.
- A registered carry links consecutive slices.
- Sits between a requesting datapath (accumulator, address generator) and the shared adder slice. Gives wide adds at low area cost, traded against latency.

---
 rtl/mcla_addseq_pkg.sv | 17 +
 rtl/mcla_16_cout.sv | 45 ++++
 rtl/mcla_addseq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mcla_addseq_pkg.sv
// Shared constants, state encoding and sizing helper for the multi-cycle wide adder.
package mcla_addseq_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of 16-bit slice passes needed for a given operand width.
    function automatic int unsigned nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/mcla_16_cout.sv
// 16-bit two-level carry-lookahead adder slice (4 groups of 4 bits).
module mcla_16_cout (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    // Bit generate/propagate, group lookahead terms and per-bit carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        gc[0] = cin;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        s    = p ^ c;
        cout = gc[4];
    end

endmodule

// File: rtl/mcla_addseq.sv
// Multi-cycle wide adder: one shared 16-bit CLA slice, LSB slice first,
// registered carry between passes. Optional subtract mode: MCLA_ADDSEQ_SUB_EN.
module mcla_addseq
    import mcla_addseq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef MCLA_ADDSEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               accept;
    logic               b_inv;

    // Shared adder slice, fed by the operand slice selected by k.
    mcla_16_cout u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

`ifdef MCLA_ADDSEQ_SUB_EN
    assign b_inv = in_sub;
`else
    assign b_inv = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    // Next-state and datapath update for the IDLE -> RUN x NSLICE -> DONE sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        slice_a = a_q[32'(k_q) * SLICE_W +: SLICE_W];
        slice_b = b_q[32'(k_q) * SLICE_W +: SLICE_W];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = b_inv ? ~in_b : in_b;
                    carry_d = b_inv ? 1'b1 : in_cin;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[32'(k_q) * SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_cout;
                if (k_q == KW'(NSLICE - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = KW'(k_q + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

endmodule
